// File: rtl/twitchcore_prefetch_if.sv
// rtl/twitchcore_prefetch_if.sv - memory fetch and instruction delivery signals of the prefetch unit
interface twitchcore_prefetch_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        i_valid;
    logic [31:0] i_data;
    logic [31:0] i_pc;
    logic        i_ready;

    modport master (
        output mem_req, mem_addr, i_valid, i_data, i_pc,
        input  mem_gnt, mem_rvalid, mem_rdata, redirect, redirect_pc, i_ready
    );

    modport slave (
        input  mem_req, mem_addr, i_valid, i_data, i_pc,
        output mem_gnt, mem_rvalid, mem_rdata, redirect, redirect_pc, i_ready
    );
endinterface

// File: rtl/twitchcore_prefetch.sv
// rtl/twitchcore_prefetch.sv - single-outstanding instruction prefetcher with redirect flush
module twitchcore_prefetch #(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          DEPTH    = 4
) (
    input logic                   clk,
    input logic                   resetn,
    twitchcore_prefetch_if.master bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_BOOT    = 2'd0,
        S_IDLE    = 2'd1,
        S_WAIT    = 2'd2,
        S_DISCARD = 2'd3
    } state_t;

    state_t         r_state;
    logic [31:0]    r_fpc;
    logic [CW-1:0]  r_cnt;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW-1:0]  r_wr_ptr;
    logic [31:0]    r_pc_mem   [DEPTH];
    logic [31:0]    r_data_mem [DEPTH];

    logic           w_req;
    logic           w_grant;
    logic           w_push;
    logic           w_pop;
    logic [31:0]    w_redirect_pc;

    // A redirect suppresses the request so no stale-path fetch is ever granted.
    assign w_redirect_pc = {bus.redirect_pc[31:2], 2'b00};
    assign w_req         = (r_state == S_IDLE) && (r_cnt < CW'(DEPTH)) && !bus.redirect;
    assign w_grant       = w_req && bus.mem_gnt;
    assign w_push        = (r_state == S_WAIT) && bus.mem_rvalid && !bus.redirect;
    assign w_pop         = (r_cnt != '0) && bus.i_ready && !bus.redirect;

    assign bus.mem_req   = w_req;
    assign bus.mem_addr  = r_fpc;
    assign bus.i_valid   = (r_cnt != '0);
    assign bus.i_data    = r_data_mem[r_rd_ptr];
    assign bus.i_pc      = r_pc_mem[r_rd_ptr];

    // Fetch FSM and fetch pointer; the pointer advances at grant, so the pushed pc is fpc-4.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_BOOT;
            r_fpc   <= RESET_PC;
        end else begin
            if (bus.redirect) begin
                r_fpc <= w_redirect_pc;
            end else if (w_grant) begin
                r_fpc <= r_fpc + 32'd4;
            end

            case (r_state)
                S_BOOT:    r_state <= S_IDLE;
                S_IDLE:    if (w_grant) r_state <= S_WAIT;
                S_WAIT: begin
                    if (bus.mem_rvalid) begin
                        r_state <= S_IDLE;
                    end else if (bus.redirect) begin
                        r_state <= S_DISCARD;
                    end
                end
                S_DISCARD: if (bus.mem_rvalid) r_state <= S_IDLE;
                default:   r_state <= S_BOOT;
            endcase
        end
    end

    // Instruction queue; a redirect empties it and voids any same-cycle push or pop.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt    <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_pc_mem[k]   <= '0;
                r_data_mem[k] <= '0;
            end
        end else if (bus.redirect) begin
            r_cnt    <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            if (w_push) begin
                r_pc_mem[r_wr_ptr]   <= r_fpc - 32'd4;
                r_data_mem[r_wr_ptr] <= bus.mem_rdata;
                r_wr_ptr             <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + CW'(1);
            end else if (!w_push && w_pop) begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end
endmodule
